// File: rtl/de0_nano_qsys2019_cmd_sequencer.sv
// Toggle-handshaked command sequencer: step/dir pulse generator plus GP output register.
// Define DE0_NANO_CMD_SEQ_STATUS_COUNT_EN to report the remaining step count in status[11:0].
module de0_nano_qsys2019_cmd_sequencer #(
  parameter int unsigned HIGH_CYC = 50,
  parameter int unsigned LOW_CYC  = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cmd_in,
  output logic [7:0]  gp_out,
  output logic        step_out,
  output logic        dir_out,
  output logic [15:0] status
);

  localparam int unsigned CMD_W = 16;
  localparam int unsigned ARG_W = 12;
  localparam int unsigned GP_W  = 8;
  localparam int unsigned PH_W  = 16;

  localparam logic [PH_W-1:0] HI_LAST = PH_W'(HIGH_CYC - 1);
  localparam logic [PH_W-1:0] LO_LAST = PH_W'(LOW_CYC - 1);

  localparam logic [2:0] OP_SET   = 3'd1;
  localparam logic [2:0] OP_STEP  = 3'd2;
  localparam logic [2:0] OP_DIR   = 3'd3;
  localparam logic [2:0] OP_ABORT = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;
  localparam logic [2:0] OP_ILL6  = 3'd6;
  localparam logic [2:0] OP_ILL7  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STEP_HI = 2'd1,
    ST_STEP_LO = 2'd2
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [CMD_W-1:0]  r_cmd_q;
  logic [PH_W-1:0]   r_phase,     w_phase_nxt;
  logic [ARG_W-1:0]  r_remaining, w_remaining_nxt;
  logic [GP_W-1:0]   r_gp,        w_gp_nxt;
  logic              r_step,      w_step_nxt;
  logic              r_dir,       w_dir_nxt;
  logic              r_ack_tog,   w_ack_tog_nxt;
  logic              r_ovr_err,   w_ovr_err_nxt;
  logic              r_ill_err,   w_ill_err_nxt;
  logic              r_busy,      w_busy_nxt;

  logic              w_pending;
  logic [2:0]        w_op;
  logic [ARG_W-1:0]  w_arg;
  logic [ARG_W-1:0]  w_status_cnt;

  assign w_pending = (r_cmd_q[15] != r_ack_tog);
  assign w_op      = r_cmd_q[14:12];
  assign w_arg     = r_cmd_q[11:0];

  // State and datapath registers; everything visible on status comes straight from here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cmd_q     <= '0;
      r_phase     <= '0;
      r_remaining <= '0;
      r_gp        <= '0;
      r_step      <= 1'b0;
      r_dir       <= 1'b0;
      r_ack_tog   <= 1'b0;
      r_ovr_err   <= 1'b0;
      r_ill_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_q     <= cmd_in;
      r_phase     <= w_phase_nxt;
      r_remaining <= w_remaining_nxt;
      r_gp        <= w_gp_nxt;
      r_step      <= w_step_nxt;
      r_dir       <= w_dir_nxt;
      r_ack_tog   <= w_ack_tog_nxt;
      r_ovr_err   <= w_ovr_err_nxt;
      r_ill_err   <= w_ill_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state: pulse sequencing first, then a command consumed while busy overrides it.
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_remaining_nxt = r_remaining;
    w_gp_nxt        = r_gp;
    w_step_nxt      = r_step;
    w_dir_nxt       = r_dir;
    w_ack_tog_nxt   = r_ack_tog;
    w_ovr_err_nxt   = r_ovr_err;
    w_ill_err_nxt   = r_ill_err;

    unique case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          w_ack_tog_nxt = r_cmd_q[15];
          case (w_op)
            OP_SET:  w_gp_nxt = w_arg[GP_W-1:0];
            OP_STEP: begin
              if (w_arg != '0) begin
                w_remaining_nxt = w_arg;
                w_state_nxt     = ST_STEP_HI;
                w_phase_nxt     = '0;
                w_step_nxt      = 1'b1;
              end
            end
            OP_DIR:  w_dir_nxt = w_arg[0];
            OP_CLEAR: begin
              w_ovr_err_nxt = 1'b0;
              w_ill_err_nxt = 1'b0;
            end
            OP_ILL6, OP_ILL7: w_ill_err_nxt = 1'b1;
            default: ;
          endcase
        end
      end
      ST_STEP_HI: begin
        if (r_phase == HI_LAST) begin
          w_state_nxt     = ST_STEP_LO;
          w_phase_nxt     = '0;
          w_step_nxt      = 1'b0;
          w_remaining_nxt = (r_remaining != '0) ? r_remaining - ARG_W'(1) : '0;
        end else begin
          w_phase_nxt = r_phase + PH_W'(1);
        end
      end
      ST_STEP_LO: begin
        if (r_phase == LO_LAST) begin
          w_phase_nxt = '0;
          if (r_remaining != '0) begin
            w_state_nxt = ST_STEP_HI;
            w_step_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_phase_nxt = r_phase + PH_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_step_nxt  = 1'b0;
      end
    endcase

    if ((r_state != ST_IDLE) && w_pending) begin
      w_ack_tog_nxt = r_cmd_q[15];
      case (w_op)
        OP_ABORT: begin
          w_remaining_nxt = '0;
          w_step_nxt      = 1'b0;
          w_phase_nxt     = '0;
          w_state_nxt     = ST_IDLE;
        end
        OP_CLEAR: begin
          w_ovr_err_nxt = 1'b0;
          w_ill_err_nxt = 1'b0;
        end
        default: w_ovr_err_nxt = 1'b1;
      endcase
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

`ifdef DE0_NANO_CMD_SEQ_STATUS_COUNT_EN
  assign w_status_cnt = r_remaining;
`else
  assign w_status_cnt = '0;
`endif

  assign gp_out   = r_gp;
  assign step_out = r_step;
  assign dir_out  = r_dir;
  assign status   = {r_busy, r_ovr_err, r_ill_err, r_ack_tog, w_status_cnt};

endmodule

// File: tb/tb_de0_nano_qsys2019_cmd_sequencer.sv
// Bench for the command sequencer: directed scenarios then random commands, each cycle
// compared against a pulse-train model built from elapsed time since the STEP started.
module tb_de0_nano_qsys2019_cmd_sequencer;

  localparam int H = 3;
  localparam int L = 2;
  localparam int P = H + L;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cmd_in;
  logic [7:0]  gp_out;
  logic        step_out;
  logic        dir_out;
  logic [15:0] status;

  int errors = 0;
  int checks = 0;

  // Model state
  logic [15:0] m_cmdq;
  logic        m_ack, m_ovr, m_ill, m_dir;
  logic [7:0]  m_gp;
  bit          m_act;
  int          m_t, m_n;
  bit          tog;

  de0_nano_qsys2019_cmd_sequencer #(.HIGH_CYC(H), .LOW_CYC(L)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_in   (cmd_in),
    .gp_out   (gp_out),
    .step_out (step_out),
    .dir_out  (dir_out),
    .status   (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_status();
    int rem;
    logic [11:0] low;
    rem = m_act ? (m_n - (m_t + L) / P) : 0;
`ifdef DE0_NANO_CMD_SEQ_STATUS_COUNT_EN
    low = 12'(rem);
`else
    low = 12'(rem) & 12'h000;
`endif
    return {m_act, m_ovr, m_ill, m_ack, low};
  endfunction

  function automatic logic exp_step();
    return m_act && ((m_t % P) < H);
  endfunction

  task automatic model_reset();
    m_cmdq = '0; m_ack = 1'b0; m_ovr = 1'b0; m_ill = 1'b0; m_dir = 1'b0;
    m_gp = '0; m_act = 0; m_t = 0; m_n = 0;
  endtask

  // One rising edge of the model: time advances, then the latched command is consumed.
  task automatic model_edge();
    bit was_busy;
    logic [2:0] op;
    logic [11:0] arg;
    was_busy = m_act;
    op  = m_cmdq[14:12];
    arg = m_cmdq[11:0];
    if (m_act) begin
      m_t++;
      if (m_t == m_n * P) m_act = 0;
    end
    if (m_cmdq[15] != m_ack) begin
      m_ack = m_cmdq[15];
      if (!was_busy) begin
        case (op)
          3'd1: m_gp = arg[7:0];
          3'd2: if (arg != 0) begin m_act = 1; m_t = 0; m_n = int'(arg); end
          3'd3: m_dir = arg[0];
          3'd5: begin m_ovr = 1'b0; m_ill = 1'b0; end
          3'd6, 3'd7: m_ill = 1'b1;
          default: ;
        endcase
      end else if (op == 3'd4) begin
        m_act = 0;
      end else if (op == 3'd5) begin
        m_ovr = 1'b0; m_ill = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end
    m_cmdq = cmd_in;
  endtask

  task automatic check_outputs();
    chk("gp_out",   16'(gp_out),   16'(m_gp));
    chk("step_out", 16'(step_out), 16'(exp_step()));
    chk("dir_out",  16'(dir_out),  16'(m_dir));
    chk("status",   status,        exp_status());
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [2:0] op, input logic [11:0] arg);
    tog = ~tog;
    cmd_in = {tog, op, arg};
  endtask

  function automatic logic [11:0] rand_arg(input logic [2:0] op);
    return (op == 3'd2) ? 12'($urandom_range(0, 4)) : 12'($urandom);
  endfunction

  initial begin
    int pulses;
    int busy_cyc;
    logic prev;
    logic [2:0] rop;

    reset = 1'b1;
    cmd_in = '0;
    tog = 0;
    model_reset();
    #2;
    check_outputs();
    chk("reset_status", status, 16'h0000);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // SET 0x1A5 with toggle=1 -> word 0x91A5
    send(3'd1, 12'h1A5);
    chk("set_word", cmd_in, 16'h91A5);
    tick();
    tick();
    chk("set_gp", 16'(gp_out), 16'h00A5);
    chk("set_status", status, 16'h1000);

    // STEP 3: three pulses, 15 busy cycles
    send(3'd2, 12'd3);
    pulses = 0; busy_cyc = 0; prev = 1'b0;
    repeat (22) begin
      tick();
      if (step_out && !prev) pulses++;
      prev = step_out;
      if (status[15]) busy_cyc++;
    end
    chk("step3_pulses", 16'(pulses), 16'd3);
    chk("step3_busy", 16'(busy_cyc), 16'd15);

    // STEP 0: nothing moves, toggle acknowledged
    send(3'd2, 12'd0);
    repeat (4) begin
      tick();
      chk("step0_busy", 16'(status[15]), 16'd0);
    end
    chk("step0_ack", 16'(status[12]), 16'(tog));

    // Overrun during STEP 10, then CLEAR
    send(3'd2, 12'd10);
    repeat (6) tick();
    send(3'd1, 12'h055);
    repeat (3) tick();
    chk("overrun_flag", 16'(status[14]), 16'd1);
    chk("overrun_gp", 16'(gp_out), 16'h00A5);
    repeat (50) tick();
    chk("overrun_done", 16'(status[15]), 16'd0);
    send(3'd5, 12'd0);
    repeat (2) tick();
    chk("clear_flag", 16'(status[14]), 16'd0);

    // ABORT during STEP 10, then DIR 1
    send(3'd2, 12'd10);
    repeat (7) tick();
    send(3'd4, 12'd0);
    tick();
    tick();
    chk("abort_step", 16'(step_out), 16'd0);
    chk("abort_busy", 16'(status[15]), 16'd0);
    chk("abort_cnt", 16'(status[11:0]), 16'd0);
    send(3'd3, 12'd1);
    repeat (2) tick();
    chk("dir_set", 16'(dir_out), 16'd1);

    // Illegal opcode 7
    send(3'd7, 12'd0);
    repeat (2) tick();
    chk("illegal_flag", 16'(status[13]), 16'd1);

    // Asynchronous reset in the middle of a step train
    send(3'd2, 12'd10);
    repeat (8) tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("midreset_status", status, 16'h0000);
    chk("midreset_step", 16'(step_out), 16'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();

    // Random commands, including payload changes with the toggle held
    repeat (800) begin
      case ($urandom_range(0, 9))
        0: begin
          rop = 3'($urandom_range(0, 7));
          send(rop, rand_arg(rop));
        end
        1: begin
          rop = 3'($urandom_range(0, 7));
          cmd_in = {tog, rop, rand_arg(rop)};
        end
        default: ;
      endcase
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
